mem_access_stage: RTL and testbench

//  Consumer side of the EX/MEM pipeline register (IR3) in the 5-stage RV64 core.

---
 rtl/riscv_pipe_pkg.sv | 21 ++
 rtl/mem_wb_reg.sv | 58 +++++
 rtl/mem_access_stage.sv | 144 ++++++++++++++
 tb/tb_mem_access_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV64 pipeline memory stage.
package riscv_pipe_pkg;

  localparam int XLEN         = 64;
  localparam int REG_ADDR_W   = 5;
  localparam int MAX_WAIT_DEF = 15;

  // Memory-stage handshake state.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Width of a counter that must be able to hold the value max_wait.
  function automatic int wait_cnt_w(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

  localparam int WAIT_CNT_W = wait_cnt_w(MAX_WAIT_DEF);

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register (IR4) with load, bubble and hold controls.
// Bubble has priority over load; with neither asserted the register holds.
module mem_wb_reg #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_bubble,
  input  logic                  i_regwrite,
  input  logic                  i_memtoreg,
  input  logic [XLEN-1:0]       i_readdata,
  input  logic [XLEN-1:0]       i_result,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output logic                  o_regwrite,
  output logic                  o_memtoreg,
  output logic [XLEN-1:0]       o_readdata,
  output logic [XLEN-1:0]       o_result,
  output logic [REG_ADDR_W-1:0] o_rd
);

  logic                  r_regwrite;
  logic                  r_memtoreg;
  logic [XLEN-1:0]       r_readdata;
  logic [XLEN-1:0]       r_result;
  logic [REG_ADDR_W-1:0] r_rd;

  // IR4 update: clear on reset or bubble, capture on load, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_readdata <= '0;
      r_result   <= '0;
      r_rd       <= '0;
    end else if (i_bubble) begin
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_readdata <= '0;
      r_result   <= '0;
      r_rd       <= '0;
    end else if (i_load) begin
      r_regwrite <= i_regwrite;
      r_memtoreg <= i_memtoreg;
      r_readdata <= i_readdata;
      r_result   <= i_result;
      r_rd       <= i_rd;
    end
  end

  assign o_regwrite = r_regwrite;
  assign o_memtoreg = r_memtoreg;
  assign o_readdata = r_readdata;
  assign o_result   = r_result;
  assign o_rd       = r_rd;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV64 core: runs loads/stores on the data memory
// through a req/ack handshake, stalls the front of the pipe while an access is
// outstanding, resolves the branch, and drives the MEM/WB register.
module mem_access_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN       = riscv_pipe_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
  parameter int MAX_WAIT   = riscv_pipe_pkg::MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite_IR3,
  input  logic                  MemtoReg_IR3,
  input  logic                  Branch_IR3,
  input  logic                  MemRead_IR3,
  input  logic                  MemWrite_IR3,
  input  logic [XLEN-1:0]       out_IR3,
  input  logic                  zero_IR3,
  input  logic [XLEN-1:0]       Result_IR3,
  input  logic [XLEN-1:0]       readData2_IR3,
  input  logic [REG_ADDR_W-1:0] instb_IR3,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  mem_stall,
  output logic                  pcsrc,
  output logic [XLEN-1:0]       branch_target,
  output logic                  mem_err,
  output logic                  RegWrite_IR4,
  output logic                  MemtoReg_IR4,
  output logic [XLEN-1:0]       ReadData_IR4,
  output logic [XLEN-1:0]       Result_IR4,
  output logic [REG_ADDR_W-1:0] instb_IR4
);

  localparam int CNT_W = wait_cnt_w(MAX_WAIT);
  // Counter value seen in the last BUSY cycle before giving up.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  mem_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_we;
  logic              r_err;

  logic              w_idle;
  logic              w_busy;
  logic              w_access;
  logic              w_start;
  logic              w_ack;
  logic              w_timeout;
  logic              w_wait;
  logic              w_ir4_load;
  logic              w_ir4_bubble;
  logic [XLEN-1:0]   w_ir4_rdata;

  assign w_idle   = (r_state == IDLE);
  assign w_busy   = (r_state == BUSY);
  assign w_access = MemRead_IR3 | MemWrite_IR3;

  // A new access is accepted only from IDLE; ack is meaningful only in BUSY.
  assign w_start   = w_idle & w_access;
  assign w_ack     = w_busy & dmem_ack;
  assign w_timeout = w_busy & ~dmem_ack & (r_cnt == CNT_LAST);
  assign w_wait    = w_busy & ~dmem_ack & ~w_timeout;

  // Entering BUSY emits a bubble; a timed-out access is dropped as a bubble too.
  assign w_ir4_bubble = w_start | w_timeout;
  assign w_ir4_load   = (w_idle & ~w_access) | w_ack;
  // Store completions and non-memory ops carry no load data.
  assign w_ir4_rdata  = (w_ack & ~r_we) ? dmem_rdata : '0;

  assign mem_stall     = w_start | w_wait;
  assign pcsrc         = Branch_IR3 & zero_IR3 & ~mem_stall;
  assign branch_target = out_IR3;

  assign dmem_req   = w_busy;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_err    = r_err;

  // Handshake FSM: latch the request on entry, count unacknowledged BUSY
  // cycles, and return to IDLE on ack or timeout (timeout sets sticky error).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_state <= BUSY;
            r_cnt   <= '0;
            r_addr  <= Result_IR3;
            r_wdata <= readData2_IR3;
            r_we    <= MemWrite_IR3;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_ir4 (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ir4_load),
    .i_bubble   (w_ir4_bubble),
    .i_regwrite (RegWrite_IR3),
    .i_memtoreg (MemtoReg_IR3),
    .i_readdata (w_ir4_rdata),
    .i_result   (Result_IR3),
    .i_rd       (instb_IR3),
    .o_regwrite (RegWrite_IR4),
    .o_memtoreg (MemtoReg_IR4),
    .o_readdata (ReadData_IR4),
    .o_result   (Result_IR4),
    .o_rd       (instb_IR4)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a random
// instruction stream checked against a transaction-level memory-stage model.
module tb_mem_access_stage;

  localparam int XLEN     = 64;
  localparam int RW       = 5;
  localparam int MAX_WAIT = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic            RegWrite_IR3, MemtoReg_IR3, Branch_IR3, MemRead_IR3, MemWrite_IR3;
  logic [XLEN-1:0] out_IR3;
  logic            zero_IR3;
  logic [XLEN-1:0] Result_IR3, readData2_IR3;
  logic [RW-1:0]   instb_IR3;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic            mem_stall, pcsrc;
  logic [XLEN-1:0] branch_target;
  logic            mem_err;
  logic            RegWrite_IR4, MemtoReg_IR4;
  logic [XLEN-1:0] ReadData_IR4, Result_IR4;
  logic [RW-1:0]   instb_IR4;

  int n_chk = 0;
  int n_err = 0;

  // Reference memory contents and sticky error expectation.
  logic [XLEN-1:0] mem [logic [XLEN-1:0]];
  logic            exp_err;

  mem_access_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_IR3(RegWrite_IR3), .MemtoReg_IR3(MemtoReg_IR3), .Branch_IR3(Branch_IR3),
    .MemRead_IR3(MemRead_IR3), .MemWrite_IR3(MemWrite_IR3), .out_IR3(out_IR3),
    .zero_IR3(zero_IR3), .Result_IR3(Result_IR3), .readData2_IR3(readData2_IR3),
    .instb_IR3(instb_IR3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .pcsrc(pcsrc), .branch_target(branch_target), .mem_err(mem_err),
    .RegWrite_IR4(RegWrite_IR4), .MemtoReg_IR4(MemtoReg_IR4), .ReadData_IR4(ReadData_IR4),
    .Result_IR4(Result_IR4), .instb_IR4(instb_IR4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] mem_rd(input logic [XLEN-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 64'hA5A5_0000_5A5A_FFFF;
  endfunction

  function automatic logic [134:0] ir4_now();
    return {RegWrite_IR4, MemtoReg_IR4, ReadData_IR4, Result_IR4, instb_IR4};
  endfunction

  // Present one instruction in IR3 and follow it until it leaves the stage.
  // n_ack = BUSY cycle in which memory acknowledges (> MAX_WAIT means never).
  // Called just after a rising edge.
  task automatic run_instr(input logic rw, input logic mtr, input logic br,
                           input logic mr, input logic mw, input logic [XLEN-1:0] tgt,
                           input logic z, input logic [XLEN-1:0] res,
                           input logic [XLEN-1:0] wd, input logic [RW-1:0] rd,
                           input int n_ack);
    logic access, got_ack, exp_stall;
    logic [XLEN-1:0] exp_rdata;
    access = mr | mw;
    RegWrite_IR3 = rw; MemtoReg_IR3 = mtr; Branch_IR3 = br; MemRead_IR3 = mr;
    MemWrite_IR3 = mw; out_IR3 = tgt; zero_IR3 = z; Result_IR3 = res;
    readData2_IR3 = wd; instb_IR3 = rd;
    // An ack strobe while idle must have no effect.
    dmem_ack   = access ? 1'b0 : 1'($urandom_range(0, 1));
    dmem_rdata = {$urandom, $urandom};
    #1;
    exp_stall = access;
    chk("stall_first", mem_stall, exp_stall);
    chk("pcsrc_first", pcsrc, br & z & ~exp_stall);
    chk("btarget", branch_target, tgt);
    chk("req_idle", dmem_req, 1'b0);
    if (!access) begin
      tick();
      dmem_ack = 1'b0;
      chk("ir4_alu", ir4_now(), {rw, mtr, 64'd0, res, rd});
    end else begin
      exp_rdata = mw ? 64'd0 : mem_rd(res);
      tick();
      for (int k = 1; k <= MAX_WAIT; k++) begin
        chk("req_busy", dmem_req, 1'b1);
        chk("addr", dmem_addr, res);
        chk("we", dmem_we, mw);
        chk("wdata", dmem_wdata, wd);
        chk("ir4_bubble", ir4_now(), 135'd0);
        got_ack    = (k == n_ack);
        dmem_ack   = got_ack;
        dmem_rdata = (got_ack && !mw) ? mem_rd(res) : {$urandom, $urandom};
        #1;
        exp_stall = !(got_ack || k == MAX_WAIT);
        chk("stall_busy", mem_stall, exp_stall);
        chk("pcsrc_busy", pcsrc, br & z & ~exp_stall);
        tick();
        dmem_ack = 1'b0;
        if (got_ack) begin
          if (mw) mem[res] = wd;
          chk("ir4_mem", ir4_now(), {rw, mtr, exp_rdata, res, rd});
          break;
        end
        if (k == MAX_WAIT) begin
          exp_err = 1'b1;
          chk("ir4_timeout", ir4_now(), 135'd0);
        end
      end
      chk("req_done", dmem_req, 1'b0);
    end
    chk("mem_err", mem_err, exp_err);
  endtask

  initial begin
    int kind, nk;
    logic [XLEN-1:0] a;
    RegWrite_IR3 = 0; MemtoReg_IR3 = 0; Branch_IR3 = 0; MemRead_IR3 = 0; MemWrite_IR3 = 0;
    out_IR3 = 0; zero_IR3 = 0; Result_IR3 = 0; readData2_IR3 = 0; instb_IR3 = 0;
    dmem_ack = 0; dmem_rdata = 0; exp_err = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir4", ir4_now(), 135'd0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_dmem", {dmem_we, dmem_addr, dmem_wdata}, 129'd0);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    reset = 1'b0;
    tick();

    // ALU op, load with ack in 3rd BUSY cycle, store with immediate ack.
    run_instr(1, 0, 0, 0, 0, 64'h0, 0, 64'h40, 64'h0, 5'd5, 0);
    mem[64'h100] = 64'h0000_0000_DEAD_BEEF;
    run_instr(1, 1, 0, 1, 0, 64'h0, 0, 64'h100, 64'h0, 5'd7, 3);
    run_instr(0, 0, 0, 0, 1, 64'h0, 0, 64'h8, 64'h1234, 5'd0, 1);
    // Both read and write set behaves as a store.
    run_instr(1, 1, 0, 1, 1, 64'h0, 0, 64'h10, 64'h55, 5'd3, 2);
    // Load that never completes, then an ALU op passes normally.
    run_instr(1, 1, 0, 1, 0, 64'h0, 0, 64'h20, 64'h0, 5'd9, 99);
    run_instr(1, 0, 0, 0, 0, 64'h0, 0, 64'h77, 64'h0, 5'd11, 0);
    // Ack on the very last allowed BUSY cycle is still accepted.
    run_instr(1, 1, 0, 1, 0, 64'h0, 0, 64'h100, 64'h0, 5'd12, MAX_WAIT);
    // Branch while idle, then branch fields on a stalled load.
    run_instr(0, 0, 1, 0, 0, 64'h200, 1, 64'h0, 64'h0, 5'd0, 0);
    run_instr(1, 1, 1, 1, 0, 64'h200, 1, 64'h100, 64'h0, 5'd4, 4);

    // Reset in the middle of an access, then a late ack.
    RegWrite_IR3 = 1; MemtoReg_IR3 = 1; MemRead_IR3 = 1; Result_IR3 = 64'h300;
    #1;
    tick();
    tick();
    chk("pre_rst_req", dmem_req, 1'b1);
    RegWrite_IR3 = 0; MemtoReg_IR3 = 0; MemRead_IR3 = 0; Result_IR3 = 0; instb_IR3 = 0;
    Branch_IR3 = 0; zero_IR3 = 0;
    #1 reset = 1'b1;
    #1;
    chk("midrst_req", dmem_req, 1'b0);
    chk("midrst_ir4", ir4_now(), 135'd0);
    chk("midrst_err", mem_err, 1'b0);
    chk("midrst_stall", mem_stall, 1'b0);
    exp_err = 1'b0;
    #1 reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dmem_ack = 1'b0;
    chk("lateack_req", dmem_req, 1'b0);
    chk("lateack_ir4", ir4_now(), 135'd0);
    chk("lateack_stall", mem_stall, 1'b0);
    chk("lateack_dmem", {dmem_we, dmem_addr, dmem_wdata}, 129'd0);

    // Random instruction stream.
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      a = {56'd0, 5'($urandom_range(0, 7)), 3'b000};
      nk = $urandom_range(1, 6);
      if ($urandom_range(0, 11) == 0) nk = MAX_WAIT + 1;
      else if ($urandom_range(0, 11) == 0) nk = MAX_WAIT;
      if (kind < 4)
        run_instr(1'($urandom), 1'($urandom), 1'($urandom), 0, 0, {$urandom, $urandom},
                  1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 0);
      else if (kind < 7)
        run_instr(1, 1, 1'($urandom), 1, 0, {$urandom, $urandom}, 1'($urandom), a,
                  {$urandom, $urandom}, 5'($urandom), nk);
      else
        run_instr(0, 0, 1'($urandom), 1'($urandom), 1, {$urandom, $urandom}, 1'($urandom), a,
                  {$urandom, $urandom}, 5'($urandom), nk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
